rv32im_alu_issue: RTL

- Operand-issue pipeline stage directly upstream of rv32im_alu.
- Accepts one decoded instruction per cycle from decode and selects operand sources: register-file data, forwarded EX/MEM result, immediate or PC.
- Resolves RAW hazards by forwarding or stalling on load-use.
- Presents registered aluoperand_1_o, aluoperand_2_o and alu_opcode_o to the ALU under a valid/ready handshake.

---
 rtl/rv32im_pkg.sv | 34 +++
 rtl/rv32im_fwd_mux.sv | 74 +++++++
 rtl/rv32im_alu_issue.sv | 125 ++++++++++++
 3 files changed

// File: rtl/rv32im_pkg.sv
// Shared widths, ALU opcodes and operand-select encoding for the rv32im issue/ALU slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rv32im_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int OPC_W  = 5;

    // ALU opcodes, bit-identical to rv32im_alu alu_opcode_i
    localparam logic [OPC_W-1:0] OP_ADD = 5'b00000;
    localparam logic [OPC_W-1:0] OP_SLL = 5'b00001;
    localparam logic [OPC_W-1:0] OP_SLT = 5'b00010;
    localparam logic [OPC_W-1:0] OP_SUB = 5'b01000;

    // Where a register source operand is taken from
    typedef enum logic [1:0] {
        SRC_ZERO = 2'd0,
        SRC_EX   = 2'd1,
        SRC_MEM  = 2'd2,
        SRC_RF   = 2'd3
    } src_sel_e;

    // Contents of the issue holding register
    typedef struct packed {
        logic [XLEN-1:0]   op1;
        logic [XLEN-1:0]   op2;
        logic [OPC_W-1:0]  opc;
        logic [REG_AW-1:0] rd;
        logic              rd_we;
        logic              is_load;
    } iss_t;

endpackage

// File: rtl/rv32im_fwd_mux.sv
// Single register-source resolver: x0 / EX forward / MEM forward / regfile, plus load-use hazard bit.
// Latency: combinational.
// Backpressure: none; hazard output is consumed by the issue stage to stall decode.
//
// Ports: rs_addr/rf_data/used describe the decoded source; ex_*/mem_* are the
// in-flight producers; src_data is the resolved value, hazard requests a stall.
// Build option RV32IM_ISSUE_FWD_EN: defined = forwarding from EX (non-load) and MEM;
// undefined = regfile only, stall on any in-flight producer of a used source.
module rv32im_fwd_mux
    import rv32im_pkg::*;
(
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [XLEN-1:0]   rf_data,
    input  logic              used,
    input  logic              ex_valid,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [XLEN-1:0]   ex_data,
    input  logic              ex_is_load,
    input  logic              mem_valid,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [XLEN-1:0]   mem_data,
    output logic [XLEN-1:0]   src_data,
    output logic              hazard
);

    logic     nonzero;
    logic     ex_hit;
    logic     mem_hit;
    src_sel_e sel;

    assign nonzero = (rs_addr != '0);
    assign ex_hit  = ex_valid  && (ex_rd  == rs_addr);
    assign mem_hit = mem_valid && (mem_rd == rs_addr);

`ifdef RV32IM_ISSUE_FWD_EN
    // A load in EX has no data yet, so it cannot forward; it falls through to
    // MEM/RF selection but the hazard bit keeps the instruction from issuing.
    always_comb begin
        sel = SRC_RF;
        if (!nonzero)
            sel = SRC_ZERO;
        else if (ex_hit && !ex_is_load)
            sel = SRC_EX;
        else if (mem_hit)
            sel = SRC_MEM;
    end

    assign hazard = used && nonzero && ex_hit && ex_is_load;
`else
    always_comb begin
        sel = SRC_RF;
        if (!nonzero)
            sel = SRC_ZERO;
    end

    // Without bypass any producer still in flight must retire first
    assign hazard = used && nonzero && (ex_hit || mem_hit);

    logic unused_fwd;
    assign unused_fwd = ex_is_load;
`endif

    always_comb begin
        src_data = '0;
        case (sel)
            SRC_ZERO: src_data = '0;
            SRC_EX:   src_data = ex_data;
            SRC_MEM:  src_data = mem_data;
            SRC_RF:   src_data = rf_data;
            default:  src_data = '0;
        endcase
    end

endmodule

// File: rtl/rv32im_alu_issue.sv
// Operand-issue stage ahead of rv32im_alu: resolves sources, muxes PC/imm, registers ALU operands.
// Latency: 1 cycle from accept to iss_valid_o.
// Backpressure: dec_ready_o drops while the held entry is stalled by EX, on a RAW hazard, or on flush.
//
// Ports: clk_i/rst_ni (async active-low), flush_i; dec_* decoded instruction in;
// ex_fwd_*/mem_fwd_* producer results; iss_valid_o/ex_ready_i handshake to EX with
// aluoperand_1_o/aluoperand_2_o/alu_opcode_o and iss_rd_addr_o/iss_rd_we_o/iss_is_load_o.
// Build option RV32IM_ISSUE_FWD_EN enables EX/MEM forwarding (see rv32im_fwd_mux).
module rv32im_alu_issue
    import rv32im_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              dec_valid_i,
    output logic              dec_ready_o,
    input  logic [XLEN-1:0]   dec_pc_i,
    input  logic [REG_AW-1:0] dec_rs1_addr_i,
    input  logic [REG_AW-1:0] dec_rs2_addr_i,
    input  logic [XLEN-1:0]   dec_rs1_data_i,
    input  logic [XLEN-1:0]   dec_rs2_data_i,
    input  logic [XLEN-1:0]   dec_imm_i,
    input  logic              dec_use_pc_i,
    input  logic              dec_use_imm_i,
    input  logic [OPC_W-1:0]  dec_alu_opcode_i,
    input  logic [REG_AW-1:0] dec_rd_addr_i,
    input  logic              dec_rd_we_i,
    input  logic              dec_is_load_i,
    input  logic              ex_fwd_valid_i,
    input  logic [REG_AW-1:0] ex_fwd_rd_i,
    input  logic [XLEN-1:0]   ex_fwd_data_i,
    input  logic              ex_fwd_is_load_i,
    input  logic              mem_fwd_valid_i,
    input  logic [REG_AW-1:0] mem_fwd_rd_i,
    input  logic [XLEN-1:0]   mem_fwd_data_i,
    output logic              iss_valid_o,
    input  logic              ex_ready_i,
    output logic [XLEN-1:0]   aluoperand_1_o,
    output logic [XLEN-1:0]   aluoperand_2_o,
    output logic [OPC_W-1:0]  alu_opcode_o,
    output logic [REG_AW-1:0] iss_rd_addr_o,
    output logic              iss_rd_we_o,
    output logic              iss_is_load_o
);

    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            hz1;
    logic            hz2;
    logic            hazard;
    logic            load;
    logic            iss_vld_q;
    iss_t            iss_q;
    iss_t            iss_d;

    rv32im_fwd_mux u_fwd_rs1 (
        .rs_addr    (dec_rs1_addr_i),
        .rf_data    (dec_rs1_data_i),
        .used       (!dec_use_pc_i),
        .ex_valid   (ex_fwd_valid_i),
        .ex_rd      (ex_fwd_rd_i),
        .ex_data    (ex_fwd_data_i),
        .ex_is_load (ex_fwd_is_load_i),
        .mem_valid  (mem_fwd_valid_i),
        .mem_rd     (mem_fwd_rd_i),
        .mem_data   (mem_fwd_data_i),
        .src_data   (src1),
        .hazard     (hz1)
    );

    rv32im_fwd_mux u_fwd_rs2 (
        .rs_addr    (dec_rs2_addr_i),
        .rf_data    (dec_rs2_data_i),
        .used       (!dec_use_imm_i),
        .ex_valid   (ex_fwd_valid_i),
        .ex_rd      (ex_fwd_rd_i),
        .ex_data    (ex_fwd_data_i),
        .ex_is_load (ex_fwd_is_load_i),
        .mem_valid  (mem_fwd_valid_i),
        .mem_rd     (mem_fwd_rd_i),
        .mem_data   (mem_fwd_data_i),
        .src_data   (src2),
        .hazard     (hz2)
    );

    assign hazard = dec_valid_i && (hz1 || hz2);

    // Room exists when the holding register is empty or being drained this cycle
    assign dec_ready_o = (!iss_vld_q || ex_ready_i) && !hazard && !flush_i;
    assign load        = dec_valid_i && dec_ready_o;

    always_comb begin
        iss_d         = '0;
        iss_d.op1     = dec_use_pc_i  ? dec_pc_i  : src1;
        iss_d.op2     = dec_use_imm_i ? dec_imm_i : src2;
        iss_d.opc     = dec_alu_opcode_i;
        iss_d.rd      = dec_rd_addr_i;
        iss_d.rd_we   = dec_rd_we_i;
        iss_d.is_load = dec_is_load_i;
    end

    // Payload only changes on load, so it stays stable while EX stalls
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            iss_vld_q <= 1'b0;
            iss_q     <= '0;
        end else if (flush_i) begin
            iss_vld_q <= 1'b0;
        end else if (load) begin
            iss_vld_q <= 1'b1;
            iss_q     <= iss_d;
        end else if (ex_ready_i) begin
            iss_vld_q <= 1'b0;
        end
    end

    assign iss_valid_o    = iss_vld_q;
    assign aluoperand_1_o = iss_q.op1;
    assign aluoperand_2_o = iss_q.op2;
    assign alu_opcode_o   = iss_q.opc;
    assign iss_rd_addr_o  = iss_q.rd;
    assign iss_rd_we_o    = iss_q.rd_we;
    assign iss_is_load_o  = iss_q.is_load;

endmodule
